// File: rtl/ab_seq_detector.sv
// Multi-channel "a-then-b" sequence detector: per channel a 2-flop synchroniser,
// rising-edge detect, IDLE/ARMED/HIT FSM with a timeout window and a saturating hit counter.
module ab_seq_detector #(
    parameter int N_CH   = 2,
    parameter int WINDOW = 8,
    parameter int CNT_W  = 8,
    parameter bit STRICT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic                  clr,
    output logic [N_CH-1:0]       c,
    output logic [2*N_CH-1:0]     state_dbg,
    output logic [N_CH*CNT_W-1:0] hit_cnt
);

    localparam int TMR_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_HIT   = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            // bit 0 is the metastability stage, bit 1 the synchronised level
            logic [1:0]       a_sync_reg, b_sync_reg;
            logic             a_d_reg, b_d_reg;
            logic             a_rise, b_rise;
            state_t           state_reg, state_next;
            logic [TMR_W-1:0] timer_reg, timer_next;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_sync_reg <= '0;
                    b_sync_reg <= '0;
                    a_d_reg    <= 1'b0;
                    b_d_reg    <= 1'b0;
                end else begin
                    a_sync_reg <= {a_sync_reg[0], a[gi]};
                    b_sync_reg <= {b_sync_reg[0], b[gi]};
                    a_d_reg    <= a_sync_reg[1];
                    b_d_reg    <= b_sync_reg[1];
                end
            end

            assign a_rise = a_sync_reg[1] & ~a_d_reg;
            assign b_rise = b_sync_reg[1] & ~b_d_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_reg <= ST_IDLE;
                    timer_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    timer_reg <= timer_next;
                end
            end

            // Timer loads WINDOW-1 on arming so ARMED lasts exactly WINDOW cycles.
            always_comb begin
                state_next = state_reg;
                timer_next = timer_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (a_rise && b_rise && !STRICT) begin
                            state_next = ST_HIT;
                        end else if (a_rise) begin
                            state_next = ST_ARMED;
                            timer_next = TMR_W'(WINDOW - 1);
                        end
                    end
                    ST_ARMED: begin
                        if (b_rise) begin
                            state_next = ST_HIT;
                        end else if (a_rise) begin
                            timer_next = TMR_W'(WINDOW - 1);
                        end else if (timer_reg == '0) begin
                            state_next = ST_IDLE;
                        end else begin
                            timer_next = timer_reg - TMR_W'(1);
                        end
                    end
                    ST_HIT:  state_next = ST_IDLE;
                    default: state_next = ST_IDLE;
                endcase
            end

            // Clear outranks a same-edge increment; count sticks at all-ones.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (clr) begin
                    cnt_reg <= '0;
                end else if (state_next == ST_HIT && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign c[gi]                        = (state_reg == ST_HIT);
            assign state_dbg[2*gi +: 2]         = state_reg;
            assign hit_cnt[CNT_W*gi +: CNT_W]   = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ab_seq_detector.sv
// Directed bench for ab_seq_detector: a STRICT=1 instance and a STRICT=0 instance share stimulus.
module tb_ab_seq_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  a, b;
    logic        clr;
    logic [1:0]  c_s, c_n;
    logic [3:0]  sd_s, sd_n;
    logic [15:0] hc_s, hc_n;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    ab_seq_detector #(.N_CH(2), .WINDOW(8), .CNT_W(8), .STRICT(1'b1)) dut_strict (
        .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr),
        .c(c_s), .state_dbg(sd_s), .hit_cnt(hc_s)
    );

    ab_seq_detector #(.N_CH(2), .WINDOW(8), .CNT_W(8), .STRICT(1'b0)) dut_loose (
        .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr),
        .c(c_n), .state_dbg(sd_n), .hit_cnt(hc_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1: reset with inputs high, then release
        reset = 1'b0; a = 2'b11; b = 2'b11; clr = 1'b0;
        tick(3);
        check("rst_c",     32'(c_s),  32'h0);
        check("rst_state", 32'(sd_s), 32'h0);
        check("rst_cnt",   32'(hc_s), 32'h0);
        reset = 1'b1;
        tick(2);
        check("rel_idle2", 32'(sd_s), 32'h0);
        tick(1);
        check("rel_armed", 32'(sd_s), 32'h5);
        check("rel_nohit", 32'(c_s),  32'h0);
        check("rel_loose_hit", 32'(c_n), 32'h3);
        a = 2'b00; b = 2'b00;
        tick(12);
        check("timeout_idle", 32'(sd_s), 32'h0);
        check("timeout_cnt",  32'(hc_s), 32'h0);

        // 2: a[0] then b[0] three clocks later
        a[0] = 1'b1;
        tick(3);
        check("t2_armed", 32'(sd_s[1:0]), 32'h1);
        b[0] = 1'b1;
        tick(2);
        check("t2_prehit", 32'(c_s), 32'h0);
        tick(1);
        check("t2_c",     32'(c_s),  32'h1);
        check("t2_state", 32'(sd_s), 32'h2);
        check("t2_cnt",   32'(hc_s), 32'h0001);
        tick(1);
        check("t2_pulse_end", 32'(c_s),  32'h0);
        check("t2_idle",      32'(sd_s), 32'h0);
        a = 2'b00; b = 2'b00;
        tick(4);

        // 3a: b rise lands in the 8th ARMED cycle -> hit
        a[0] = 1'b1;
        tick(8);
        b[0] = 1'b1;
        tick(3);
        check("t3_win8_c",   32'(c_s),  32'h1);
        check("t3_win8_cnt", 32'(hc_s), 32'h0002);
        a = 2'b00; b = 2'b00;
        tick(4);

        // 3b: b rise one cycle too late -> no hit
        a[0] = 1'b1;
        tick(9);
        b[0] = 1'b1;
        check("t3_cyc7_armed", 32'(sd_s[1:0]), 32'h1);
        tick(1);
        check("t3_cyc8_armed", 32'(sd_s[1:0]), 32'h1);
        tick(1);
        check("t3_expired", 32'(sd_s[1:0]), 32'h0);
        tick(1);
        check("t3_late_c",   32'(c_s),  32'h0);
        check("t3_late_cnt", 32'(hc_s), 32'h0002);
        a = 2'b00; b = 2'b00;
        tick(4);

        // 4: simultaneous a/b rise on ch1, strict vs loose
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t4_clr_s", 32'(hc_s), 32'h0);
        check("t4_clr_n", 32'(hc_n), 32'h0);
        a[1] = 1'b1; b[1] = 1'b1;
        tick(3);
        check("t4_strict_state", 32'(sd_s[3:2]), 32'h1);
        check("t4_strict_c",     32'(c_s),       32'h0);
        check("t4_loose_state",  32'(sd_n[3:2]), 32'h2);
        check("t4_loose_c",      32'(c_n),       32'h2);
        check("t4_loose_cnt",    32'(hc_n),      32'h0100);
        a = 2'b00; b = 2'b00;
        tick(12);
        check("t4_strict_cnt", 32'(hc_s), 32'h0000);

        // 5: 260 hits on ch0 saturate the counter
        for (int i = 0; i < 260; i++) begin
            a[0] = 1'b1;
            tick(1);
            b[0] = 1'b1;
            tick(1);
            a[0] = 1'b0; b[0] = 1'b0;
            tick(2);
            if (i == 99) check("t5_cnt100", 32'(hc_s), 32'h0064);
        end
        tick(4);
        check("t5_sat_s", 32'(hc_s), 32'h00FF);
        check("t5_sat_n", 32'(hc_n), 32'h01FF);
        a[0] = 1'b1;
        tick(1);
        b[0] = 1'b1;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t5_clr_hit_c",   32'(c_s),  32'h1);
        check("t5_clr_hit_cnt", 32'(hc_s), 32'h0000);
        a = 2'b00; b = 2'b00;
        tick(4);

        // 6: async reset while ARMED
        a = 2'b11;
        tick(4);
        check("t6_armed", 32'(sd_s), 32'h5);
        #5;
        reset = 1'b0;
        #1;
        check("t6_async_state", 32'(sd_s), 32'h0);
        check("t6_async_c",     32'(c_s),  32'h0);
        check("t6_async_cnt_n", 32'(hc_n), 32'h0);
        a = 2'b00;
        tick(2);
        reset = 1'b1;
        tick(5);
        check("t6_stay_idle", 32'(sd_s), 32'h0);
        a[0] = 1'b1;
        tick(3);
        check("t6_rearm", 32'(sd_s), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
